// File: rtl/execute_wb_history.sv
// Two-deep writeback history (CUR/PREV) for execute-stage forwarding.
// Optional FRCR tracking: define EXECUTE_WB_HISTORY_FRCR_EN.
module execute_wb_history #(
  parameter logic [31:0] P_SPR_RESET  = 32'h0000_0000,
  parameter logic [63:0] P_FRCR_RESET = 64'h0
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iFLUSH,
  input  logic        iWB_GR_VALID,
  input  logic [31:0] iWB_GR_DATA,
  input  logic [4:0]  iWB_GR_DEST,
  input  logic        iWB_GR_DEST_SYSREG,
  input  logic        iWB_SPR_VALID,
  input  logic [31:0] iWB_SPR_DATA,
  input  logic        iWB_FRCR_VALID,
  input  logic [63:0] iWB_FRCR_DATA,
  output logic        oCUR_GR_VALID,
  output logic [31:0] oCUR_GR_DATA,
  output logic [4:0]  oCUR_GR_DEST,
  output logic        oCUR_GR_DEST_SYSREG,
  output logic        oCUR_SPR_VALID,
  output logic [31:0] oCUR_SPR_DATA,
  output logic        oCUR_FRCR_VALID,
  output logic [63:0] oCUR_FRCR_DATA,
  output logic        oPREV_GR_VALID,
  output logic [31:0] oPREV_GR_DATA,
  output logic [4:0]  oPREV_GR_DEST,
  output logic        oPREV_GR_DEST_SYSREG,
  output logic        oPREV_SPR_VALID,
  output logic [31:0] oPREV_SPR_DATA,
  output logic        oPREV_FRCR_VALID,
  output logic [63:0] oPREV_FRCR_DATA,
  output logic [1:0]  oHISTORY_DEPTH
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } depth_t;

  depth_t r_state;
  depth_t w_state_nxt;
  logic   w_frcr_vld;
  logic   w_evt;

`ifdef EXECUTE_WB_HISTORY_FRCR_EN
  assign w_frcr_vld = iWB_FRCR_VALID;
`else
  assign w_frcr_vld = 1'b0;
`endif

  assign w_evt = iWB_GR_VALID | iWB_SPR_VALID | w_frcr_vld;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) r_state <= S_EMPTY;
    else             r_state <= w_state_nxt;
  end

  // Encoding 2'b11 falls into the default arm and behaves as TWO.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_evt) w_state_nxt = S_ONE;
      S_ONE:   if (w_evt) w_state_nxt = S_TWO;
      default: w_state_nxt = S_TWO;
    endcase
    if (iFLUSH) w_state_nxt = w_evt ? S_ONE : S_EMPTY;
  end

  assign oHISTORY_DEPTH = (r_state == S_EMPTY) ? 2'd0 :
                          (r_state == S_ONE)   ? 2'd1 : 2'd2;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      oCUR_GR_VALID        <= 1'b0;
      oCUR_GR_DATA         <= '0;
      oCUR_GR_DEST         <= '0;
      oCUR_GR_DEST_SYSREG  <= 1'b0;
      oCUR_SPR_VALID       <= 1'b0;
      oCUR_SPR_DATA        <= P_SPR_RESET;
      oPREV_GR_VALID       <= 1'b0;
      oPREV_GR_DATA        <= '0;
      oPREV_GR_DEST        <= '0;
      oPREV_GR_DEST_SYSREG <= 1'b0;
      oPREV_SPR_VALID      <= 1'b0;
      oPREV_SPR_DATA       <= P_SPR_RESET;
    end else if (w_evt) begin
      // A committed writeback survives a same-cycle flush; only PREV dies.
      oPREV_GR_VALID       <= oCUR_GR_VALID & ~iFLUSH;
      oPREV_GR_DATA        <= oCUR_GR_DATA;
      oPREV_GR_DEST        <= oCUR_GR_DEST;
      oPREV_GR_DEST_SYSREG <= oCUR_GR_DEST_SYSREG;
      oPREV_SPR_VALID      <= oCUR_SPR_VALID & ~iFLUSH;
      oPREV_SPR_DATA       <= oCUR_SPR_DATA;
      oCUR_GR_VALID        <= iWB_GR_VALID;
      oCUR_SPR_VALID       <= iWB_SPR_VALID;
      if (iWB_GR_VALID) begin
        oCUR_GR_DATA        <= iWB_GR_DATA;
        oCUR_GR_DEST        <= iWB_GR_DEST;
        oCUR_GR_DEST_SYSREG <= iWB_GR_DEST_SYSREG;
      end
      if (iWB_SPR_VALID) oCUR_SPR_DATA <= iWB_SPR_DATA;
    end else if (iFLUSH) begin
      oCUR_GR_VALID   <= 1'b0;
      oCUR_SPR_VALID  <= 1'b0;
      oPREV_GR_VALID  <= 1'b0;
      oPREV_SPR_VALID <= 1'b0;
    end
  end

`ifdef EXECUTE_WB_HISTORY_FRCR_EN
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      oCUR_FRCR_VALID  <= 1'b0;
      oCUR_FRCR_DATA   <= P_FRCR_RESET;
      oPREV_FRCR_VALID <= 1'b0;
      oPREV_FRCR_DATA  <= P_FRCR_RESET;
    end else if (w_evt) begin
      oPREV_FRCR_VALID <= oCUR_FRCR_VALID & ~iFLUSH;
      oPREV_FRCR_DATA  <= oCUR_FRCR_DATA;
      oCUR_FRCR_VALID  <= iWB_FRCR_VALID;
      if (iWB_FRCR_VALID) oCUR_FRCR_DATA <= iWB_FRCR_DATA;
    end else if (iFLUSH) begin
      oCUR_FRCR_VALID  <= 1'b0;
      oPREV_FRCR_VALID <= 1'b0;
    end
  end
`else
  logic w_unused_frcr;
  assign w_unused_frcr    = ^{iWB_FRCR_VALID, iWB_FRCR_DATA};
  assign oCUR_FRCR_VALID  = 1'b0;
  assign oCUR_FRCR_DATA   = P_FRCR_RESET;
  assign oPREV_FRCR_VALID = 1'b0;
  assign oPREV_FRCR_DATA  = P_FRCR_RESET;
`endif

endmodule

// File: tb/tb_execute_wb_history.sv
// Directed self-checking bench for execute_wb_history.
// Expectations follow EXECUTE_WB_HISTORY_FRCR_EN when it is defined.
module tb_execute_wb_history;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        gr_v;
  logic [31:0] gr_d;
  logic [4:0]  gr_dst;
  logic        gr_sys;
  logic        spr_v;
  logic [31:0] spr_d;
  logic        frcr_v;
  logic [63:0] frcr_d;

  logic        c_gr_v, p_gr_v, c_gr_sys, p_gr_sys;
  logic [31:0] c_gr_d, p_gr_d;
  logic [4:0]  c_gr_dst, p_gr_dst;
  logic        c_spr_v, p_spr_v;
  logic [31:0] c_spr_d, p_spr_d;
  logic        c_fr_v, p_fr_v;
  logic [63:0] c_fr_d, p_fr_d;
  logic [1:0]  depth;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_wb_history dut (
    .iCLOCK               (clk),
    .iRESET_SYNC          (rst),
    .iFLUSH               (flush),
    .iWB_GR_VALID         (gr_v),
    .iWB_GR_DATA          (gr_d),
    .iWB_GR_DEST          (gr_dst),
    .iWB_GR_DEST_SYSREG   (gr_sys),
    .iWB_SPR_VALID        (spr_v),
    .iWB_SPR_DATA         (spr_d),
    .iWB_FRCR_VALID       (frcr_v),
    .iWB_FRCR_DATA        (frcr_d),
    .oCUR_GR_VALID        (c_gr_v),
    .oCUR_GR_DATA         (c_gr_d),
    .oCUR_GR_DEST         (c_gr_dst),
    .oCUR_GR_DEST_SYSREG  (c_gr_sys),
    .oCUR_SPR_VALID       (c_spr_v),
    .oCUR_SPR_DATA        (c_spr_d),
    .oCUR_FRCR_VALID      (c_fr_v),
    .oCUR_FRCR_DATA       (c_fr_d),
    .oPREV_GR_VALID       (p_gr_v),
    .oPREV_GR_DATA        (p_gr_d),
    .oPREV_GR_DEST        (p_gr_dst),
    .oPREV_GR_DEST_SYSREG (p_gr_sys),
    .oPREV_SPR_VALID      (p_spr_v),
    .oPREV_SPR_DATA       (p_spr_d),
    .oPREV_FRCR_VALID     (p_fr_v),
    .oPREV_FRCR_DATA      (p_fr_d),
    .oHISTORY_DEPTH       (depth)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; gr_v = 0; spr_v = 0; frcr_v = 0;
  endtask

  task automatic gr(input logic [4:0] dst, input logic [31:0] d);
    gr_v = 1; gr_dst = dst; gr_d = d;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1; gr_d = '0; gr_dst = '0; gr_sys = 0;
    spr_d = '0; frcr_d = '0;
    tick(); tick();
    rst = 0;
    check("rst_depth", 64'(depth), 64'd0);
    check("rst_cur_gr_v", 64'(c_gr_v), 64'd0);
    check("rst_prev_spr_v", 64'(p_spr_v), 64'd0);
    check("rst_cur_gr_d", 64'(c_gr_d), 64'd0);
    check("rst_cur_spr_d", 64'(c_spr_d), 64'd0);

    // 1: first GR write
    gr(5'd5, 32'hA5A5_0001);
    check("t1_cur_v", 64'(c_gr_v), 64'd1);
    check("t1_cur_dst", 64'(c_gr_dst), 64'd5);
    check("t1_cur_d", 64'(c_gr_d), 64'hA5A5_0001);
    check("t1_prev_v", 64'(p_gr_v), 64'd0);
    check("t1_depth", 64'(depth), 64'd1);

    // 2: idle gaps never age the history
    gr(5'd1, 32'h11);
    repeat (4) tick();
    gr(5'd2, 32'h22);
    repeat (4) tick();
    gr(5'd3, 32'h33);
    check("t2_cur_dst", 64'(c_gr_dst), 64'd3);
    check("t2_prev_dst", 64'(p_gr_dst), 64'd2);
    check("t2_depth", 64'(depth), 64'd2);
    repeat (4) tick();
    check("t2_idle_cur", 64'(c_gr_dst), 64'd3);
    check("t2_idle_prev", 64'(p_gr_dst), 64'd2);
    check("t2_idle_pd", 64'(p_gr_d), 64'h22);
    check("t2_idle_depth", 64'(depth), 64'd2);

    // 3: sticky SPR data
    spr_v = 1; spr_d = 32'h0000_1000;
    tick(); idle();
    gr(5'd4, 32'h44);
    check("t3_cur_spr_v", 64'(c_spr_v), 64'd0);
    check("t3_cur_spr_d", 64'(c_spr_d), 64'h1000);
    check("t3_prev_spr_v", 64'(p_spr_v), 64'd1);
    check("t3_prev_spr_d", 64'(p_spr_d), 64'h1000);
    check("t3_prev_gr_v", 64'(p_gr_v), 64'd0);
    check("t3_depth_sat", 64'(depth), 64'd2);

    // 4: flush alone, then flush with event
    flush = 1; tick(); idle();
    check("t4_cur_gr_v", 64'(c_gr_v), 64'd0);
    check("t4_prev_spr_v", 64'(p_spr_v), 64'd0);
    check("t4_depth", 64'(depth), 64'd0);
    check("t4_data_kept", 64'(c_gr_dst), 64'd4);
    flush = 1; gr(5'd7, 32'h77);
    check("t4b_cur_v", 64'(c_gr_v), 64'd1);
    check("t4b_cur_dst", 64'(c_gr_dst), 64'd7);
    check("t4b_prev_v", 64'(p_gr_v), 64'd0);
    check("t4b_depth", 64'(depth), 64'd1);

    // 4c: flush+event at depth 2 collapses to one
    gr(5'd8, 32'h88);
    flush = 1; gr(5'd9, 32'h99);
    check("t4c_prev_v", 64'(p_gr_v), 64'd0);
    check("t4c_depth", 64'(depth), 64'd1);
    check("t4c_cur_dst", 64'(c_gr_dst), 64'd9);

    // 5: GR + SPR same cycle form one entry
    gr_sys = 1; spr_v = 1; spr_d = 32'h0000_2000;
    gr(5'd31, 32'hDEAD_0031);
    gr_sys = 0;
    check("t5_cur_gr_v", 64'(c_gr_v), 64'd1);
    check("t5_cur_dst", 64'(c_gr_dst), 64'd31);
    check("t5_cur_sys", 64'(c_gr_sys), 64'd1);
    check("t5_cur_spr_v", 64'(c_spr_v), 64'd1);
    check("t5_cur_spr_d", 64'(c_spr_d), 64'h2000);
    check("t5_prev_dst", 64'(p_gr_dst), 64'd9);
    check("t5_prev_v", 64'(p_gr_v), 64'd1);
    check("t5_depth", 64'(depth), 64'd2);

    // 6: FRCR-only event
    flush = 1; tick(); idle();
    gr(5'd10, 32'hAA);
    frcr_v = 1; frcr_d = 64'h1234_5678_9ABC_DEF0;
    tick(); idle();
`ifdef EXECUTE_WB_HISTORY_FRCR_EN
    check("t6_cur_fr_v", 64'(c_fr_v), 64'd1);
    check("t6_cur_fr_d", c_fr_d, 64'h1234_5678_9ABC_DEF0);
    check("t6_cur_gr_v", 64'(c_gr_v), 64'd0);
    check("t6_prev_dst", 64'(p_gr_dst), 64'd10);
    check("t6_depth", 64'(depth), 64'd2);
`else
    check("t6_cur_fr_v", 64'(c_fr_v), 64'd0);
    check("t6_cur_fr_d", c_fr_d, 64'h0);
    check("t6_prev_fr_d", p_fr_d, 64'h0);
    check("t6_cur_gr_v", 64'(c_gr_v), 64'd1);
    check("t6_cur_dst", 64'(c_gr_dst), 64'd10);
    check("t6_depth", 64'(depth), 64'd1);
`endif

    // reset beats a concurrent event
    rst = 1; gr(5'd12, 32'hCC);
    rst = 0;
    check("rst_evt_v", 64'(c_gr_v), 64'd0);
    check("rst_evt_d", 64'(c_gr_d), 64'd0);
    check("rst_evt_spr_d", 64'(c_spr_d), 64'd0);
    check("rst_evt_depth", 64'(depth), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
